// File: rtl/instr_issue_unit_if.sv
// Issue-side bus of the instruction issue unit: the instruction handshake
// toward decode plus the branch-resolution feedback from the datapath.
interface instr_issue_unit_if #(
    parameter int ADDR_W = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr;
    logic [1:0]        opcode;
    logic [ADDR_W-1:0] pc;
    logic              br_resolve;
    logic              br_taken;

    // Issue unit side
    modport master (
        output instr_valid,
        output instr,
        output opcode,
        output pc,
        input  instr_ready,
        input  br_resolve,
        input  br_taken
    );

    // Decode / datapath side
    modport slave (
        input  instr_valid,
        input  instr,
        input  opcode,
        input  pc,
        output instr_ready,
        output br_resolve,
        output br_taken
    );
endinterface

// File: rtl/instr_issue_unit.sv
// Instruction fetch/issue unit: loadable 8-bit program memory, program
// counter, valid/ready issue of one instruction per cycle, and a stall on
// each branch until the datapath resolves it.
module instr_issue_unit #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              start,
    instr_issue_unit_if.master bus,
    output logic              busy,
    output logic              halted
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic [7:0]        mem [0:DEPTH-1];
    logic [7:0]        cur_instr;
    logic [ADDR_W-1:0] seq_next;
    logic [ADDR_W-1:0] br_target;
    logic              is_branch;
    logic              load_ok;

    // Branch target: pc + 1 + sign-extended 2-bit offset (-2..+1), wrapping
    // modulo the memory depth. Not-taken is simply pc + 1.
    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0] base,
        input logic [1:0]        imm,
        input logic              taken
    );
        logic signed [ADDR_W-1:0] offset;
        offset = taken ? {{(ADDR_W-2){imm[1]}}, imm} : '0;
        return base + ADDR_W'(1) + $unsigned(offset);
    endfunction

    assign cur_instr = mem[pc_q];
    assign is_branch = (cur_instr[7:6] == 2'b11);
    assign seq_next  = pc_q + ADDR_W'(1);
    assign br_target = branch_target(pc_q, cur_instr[1:0], bus.br_taken);
    assign load_ok   = load_en && ((state == S_IDLE) || (state == S_HALT));

    assign bus.instr_valid = (state == S_RUN);
    assign bus.instr       = cur_instr;
    assign bus.opcode      = cur_instr[7:6];
    assign bus.pc          = pc_q;
    assign busy            = (state == S_RUN) || (state == S_WAIT);
    assign halted          = (state == S_HALT);

    // Program memory write port; contents survive reset on purpose so a
    // loaded program can be rerun after a reset.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    // Next-state and next-PC decision for the issue sequencer.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = (prog_len == '0) ? S_HALT : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.instr_ready) begin
                    if (is_branch) begin
                        state_nxt = S_WAIT;
                    end else if ((seq_next >= prog_len) || (seq_next == '0)) begin
                        // Falling off the end (or wrapping) halts with pc on
                        // the last issued instruction.
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt = seq_next;
                    end
                end
            end
            S_WAIT: begin
                if (bus.br_resolve) begin
                    pc_nxt    = br_target;
                    state_nxt = (br_target >= prog_len) ? S_HALT : S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sequencer state and program counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pc_q  <= '0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
        end
    end
endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed testbench for instr_issue_unit.
module tb_instr_issue_unit;
    logic       clk;
    logic       reset_n;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic [3:0] prog_len;
    logic       start;
    logic       busy;
    logic       halted;
    int         checks;
    int         failures;

    instr_issue_unit_if #(.ADDR_W(4)) bus ();

    instr_issue_unit #(.ADDR_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .prog_len  (prog_len),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic resolve(input logic taken);
        bus.br_resolve = 1'b1;
        bus.br_taken   = taken;
        step();
        bus.br_resolve = 1'b0;
        bus.br_taken   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
        checks++; if (bus.pc !== 4'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", bus.pc); end
        step();
        step();
        reset_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%0b halted=%0b exp=0/0", busy, halted); end
    endtask

    task automatic test_basic();
        logic [1:0] ops [5];
        ops = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        load_word(4'd0, 8'h1B);
        load_word(4'd1, 8'h46);
        load_word(4'd2, 8'h84);
        load_word(4'd3, 8'h39);
        load_word(4'd4, 8'h00);
        prog_len = 4'd5;
        bus.instr_ready = 1'b1;
        pulse_start();
        checks++; if (bus.instr !== 8'h1B) begin failures++; $display("FAIL basic_instr0 got=%0h exp=1b", bus.instr); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== 4'(i) || bus.opcode !== ops[i]) begin
                failures++; $display("FAIL basic_issue%0d valid=%0b pc=%0d op=%0b exp=1/%0d/%0b", i, bus.instr_valid, bus.pc, bus.opcode, i, ops[i]);
            end
            step();
        end
        checks++; if (halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== 4'd4) begin
            failures++; $display("FAIL basic_halt halted=%0b valid=%0b pc=%0d exp=1/0/4", halted, bus.instr_valid, bus.pc);
        end
    endtask

    task automatic test_stall();
        bus.instr_ready = 1'b1;
        pulse_start();
        checks++; if (bus.pc !== 4'd0 || bus.instr_valid !== 1'b1) begin failures++; $display("FAIL stall_restart pc=%0d valid=%0b exp=0/1", bus.pc, bus.instr_valid); end
        step();
        step();
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.pc !== 4'd2 || bus.instr !== 8'h84 || bus.opcode !== 2'b10 || bus.instr_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d pc=%0d instr=%0h op=%0b valid=%0b exp=2/84/10/1", k, bus.pc, bus.instr, bus.opcode, bus.instr_valid);
            end
            if (k == 1) start = 1'b1;
            step();
            start = 1'b0;
        end
        checks++; if (bus.pc !== 4'd2) begin failures++; $display("FAIL stall_start_ignored pc=%0d exp=2", bus.pc); end
        bus.instr_ready = 1'b1;
        step();
        checks++; if (bus.pc !== 4'd3 || bus.instr !== 8'h39) begin failures++; $display("FAIL stall_resume pc=%0d instr=%0h exp=3/39", bus.pc, bus.instr); end
        step();
        step();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL stall_halt got=%0b exp=1", halted); end
    endtask

    task automatic test_branch();
        logic [3:0] exp_pc;
        load_word(4'd0, 8'h00);
        load_word(4'd1, 8'hC1);
        load_word(4'd2, 8'h40);
        load_word(4'd3, 8'h80);
        load_word(4'd4, 8'h00);
        load_word(4'd5, 8'h00);
        prog_len = 4'd6;
        bus.instr_ready = 1'b1;
        for (int t = 1; t >= 0; t--) begin
            exp_pc = (t == 1) ? 4'd3 : 4'd2;
            pulse_start();
            step();
            checks++; if (bus.pc !== 4'd1 || bus.opcode !== 2'b11 || bus.instr_valid !== 1'b1) begin
                failures++; $display("FAIL br%0d_offer pc=%0d op=%0b valid=%0b exp=1/11/1", t, bus.pc, bus.opcode, bus.instr_valid);
            end
            step();
            checks++; if (bus.instr_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL br%0d_bubble1 valid=%0b busy=%0b exp=0/1", t, bus.instr_valid, busy); end
            step();
            checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== 4'd1) begin failures++; $display("FAIL br%0d_bubble2 valid=%0b pc=%0d exp=0/1", t, bus.instr_valid, bus.pc); end
            resolve(t[0]);
            checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== exp_pc) begin
                failures++; $display("FAIL br%0d_target valid=%0b pc=%0d exp=1/%0d", t, bus.instr_valid, bus.pc, exp_pc);
            end
            for (int k = 0; k < 10 && !halted; k++) step();
            checks++; if (halted !== 1'b1) begin failures++; $display("FAIL br%0d_end halted=%0b exp=1", t, halted); end
        end
    endtask

    task automatic test_loop();
        logic [3:0] exp_seq [3];
        logic       tk [3];
        exp_seq = '{4'd3, 4'd3, 4'd4};
        tk      = '{1'b1, 1'b1, 1'b0};
        load_word(4'd0, 8'h00);
        load_word(4'd1, 8'h00);
        load_word(4'd2, 8'h00);
        load_word(4'd3, 8'hC3);
        load_word(4'd4, 8'h00);
        load_word(4'd5, 8'hC1);
        prog_len = 4'd6;
        bus.instr_ready = 1'b1;
        pulse_start();
        step();
        step();
        step();
        checks++; if (bus.pc !== 4'd3 || bus.opcode !== 2'b11) begin failures++; $display("FAIL loop_entry pc=%0d op=%0b exp=3/11", bus.pc, bus.opcode); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL loop_wait%0d valid=%0b exp=0", i, bus.instr_valid); end
            resolve(tk[i]);
            checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== exp_seq[i]) begin
                failures++; $display("FAIL loop_pc%0d valid=%0b pc=%0d exp=1/%0d", i, bus.instr_valid, bus.pc, exp_seq[i]);
            end
        end
        step();
        checks++; if (bus.pc !== 4'd5 || bus.opcode !== 2'b11) begin failures++; $display("FAIL loop_far_branch pc=%0d op=%0b exp=5/11", bus.pc, bus.opcode); end
        step();
        resolve(1'b1);
        checks++; if (halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== 4'd7) begin
            failures++; $display("FAIL loop_far_halt halted=%0b valid=%0b pc=%0d exp=1/0/7", halted, bus.instr_valid, bus.pc);
        end
        step();
        step();
        checks++; if (bus.instr_valid !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL loop_stay_halt valid=%0b halted=%0b exp=0/1", bus.instr_valid, halted); end
    endtask

    task automatic test_empty();
        prog_len = 4'd0;
        pulse_start();
        checks++; if (halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== 4'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL empty_halt halted=%0b valid=%0b pc=%0d busy=%0b exp=1/0/0/0", halted, bus.instr_valid, bus.pc, busy);
        end
        step();
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL empty_novalid got=%0b exp=0", bus.instr_valid); end
        prog_len  = 4'd1;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 8'h80;
        pulse_start();
        load_en   = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== 4'd0 || bus.instr !== 8'h80 || bus.opcode !== 2'b10) begin
            failures++; $display("FAIL start_load valid=%0b pc=%0d instr=%0h op=%0b exp=1/0/80/10", bus.instr_valid, bus.pc, bus.instr, bus.opcode);
        end
        step();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL start_load_halt got=%0b exp=1", halted); end
    endtask

    task automatic test_load_in_run();
        prog_len = 4'd2;
        bus.instr_ready = 1'b0;
        pulse_start();
        load_en   = 1'b1;
        load_addr = 4'd1;
        load_data = 8'hFF;
        step();
        load_en = 1'b0;
        bus.instr_ready = 1'b1;
        checks++; if (bus.pc !== 4'd0 || bus.instr_valid !== 1'b1) begin failures++; $display("FAIL run_load_hold pc=%0d valid=%0b exp=0/1", bus.pc, bus.instr_valid); end
        step();
        checks++; if (bus.pc !== 4'd1 || bus.instr !== 8'h00) begin failures++; $display("FAIL run_load_ignored pc=%0d instr=%0h exp=1/00", bus.pc, bus.instr); end
        step();
        pulse_start();
        step();
        checks++; if (bus.pc !== 4'd1 || bus.instr !== 8'h00) begin failures++; $display("FAIL run_load_rerun pc=%0d instr=%0h exp=1/00", bus.pc, bus.instr); end
        step();
    endtask

    task automatic test_reset_mid();
        prog_len = 4'd6;
        bus.instr_ready = 1'b1;
        pulse_start();
        step();
        reset_n = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || bus.pc !== 4'd0) begin
            failures++; $display("FAIL rst_run valid=%0b busy=%0b halted=%0b pc=%0d exp=0/0/0/0", bus.instr_valid, busy, halted, bus.pc);
        end
        #2 reset_n = 1'b1;
        pulse_start();
        step();
        step();
        step();
        step();
        checks++; if (busy !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== 4'd3) begin
            failures++; $display("FAIL rst_pre_wait busy=%0b valid=%0b pc=%0d exp=1/0/3", busy, bus.instr_valid, bus.pc);
        end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || bus.pc !== 4'd0) begin
            failures++; $display("FAIL rst_wait valid=%0b busy=%0b halted=%0b pc=%0d exp=0/0/0/0", bus.instr_valid, busy, halted, bus.pc);
        end
        #2 reset_n = 1'b1;
        resolve(1'b1);
        checks++; if (busy !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 4'd0) begin
            failures++; $display("FAIL idle_resolve busy=%0b valid=%0b pc=%0d exp=0/0/0", busy, bus.instr_valid, bus.pc);
        end
        pulse_start();
        checks++; if (bus.pc !== 4'd0 || bus.instr !== 8'h80) begin failures++; $display("FAIL rst_retain0 pc=%0d instr=%0h exp=0/80", bus.pc, bus.instr); end
        step();
        step();
        step();
        checks++; if (bus.pc !== 4'd3 || bus.instr !== 8'hC3) begin failures++; $display("FAIL rst_retain3 pc=%0d instr=%0h exp=3/c3", bus.pc, bus.instr); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset_n         = 1'b1;
        load_en         = 1'b0;
        load_addr       = '0;
        load_data       = '0;
        prog_len        = '0;
        start           = 1'b0;
        bus.instr_ready = 1'b0;
        bus.br_resolve  = 1'b0;
        bus.br_taken    = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_loop();
        test_empty();
        test_load_in_run();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_issue_unit.md
# instr_issue_unit

Instruction fetch/issue block that produces the 2-bit opcode stream consumed by the control unit. It holds a small loadable program memory of 8-bit instructions and a program counter, and presents one instruction at a time over a valid/ready handshake. It stalls on branches until the datapath resolves them, then redirects the PC. It sits between the program loader (testbench or boot logic) and the decode/control stage.

## Interface
Parameters:
- ADDR_W, 4: PC and memory address width; memory depth is 2**ADDR_W words of 8 bits.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  program-memory write strobe; honoured only in IDLE or HALT.
- load_addr  in  ADDR_W  write address.
- load_data  in  8  instruction word to write.
- prog_len  in  ADDR_W  number of valid instructions; PC values >= prog_len end execution. Sampled continuously, so it must be held stable while busy.
- start  in  1  pulse; from IDLE or HALT, sets PC=0 and begins execution.
- instr_valid  out  1  instruction on instr/opcode/pc is offered downstream.
- instr_ready  in  1  downstream accepts; a transfer occurs when instr_valid && instr_ready.
- instr  out  8  mem[pc]. Format: [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd/imm.
- opcode  out  2  instr[7:6]. Encoding: 00 R-type, 01 load, 10 store, 11 branch.
- pc  out  ADDR_W  address of the offered instruction.
- br_resolve  in  1  datapath pulse; the outstanding branch is resolved this cycle.
- br_taken  in  1  qualifies br_resolve: 1 = taken.
- busy  out  1  high in RUN or WAIT_BR.
- halted  out  1  high in HALT.

## Operation
- States: IDLE, RUN, WAIT_BR, HALT.
- Reset: state=IDLE, pc=0, instr_valid=0, busy=0, halted=0. Memory contents are not reset. instr/opcode are don't-care while instr_valid=0.
- Memory: synchronous write and combinational read. A load_en write at edge N is visible on instr from cycle N+1. Writes in RUN or WAIT_BR are ignored.
- IDLE/HALT + start: pc<=0. The next state is HALT if prog_len==0, otherwise RUN.
- If start and load_en arrive in the same cycle, both take effect. The word written is visible when RUN begins.
- start while busy: ignored.
- RUN: instr_valid=1 and instr=mem[pc]. Outputs hold stable while instr_ready=0.
- Transfer of a non-branch (opcode != 11): next = pc+1 mod 2**ADDR_W.
  - If next >= prog_len or next==0 (wrapped), go to HALT.
  - Otherwise pc<=next and stay in RUN. Back-to-back transfers issue one instruction per cycle.
- Transfer of a branch (opcode == 11): go to WAIT_BR with pc held, and instr_valid=0 from the next cycle.
- WAIT_BR: wait for br_resolve. br_resolve in RUN or IDLE is ignored.
  - Taken: target = pc + 1 + sext(instr[1:0]), where the offset range is -2..+1, mod 2**ADDR_W.
  - Not taken: target = pc + 1.
  - If target >= prog_len, go to HALT with pc<=target. Otherwise go to RUN with pc<=target.
  - sext 11 (-1) with taken gives target=pc, so a one-instruction loop is legal.
- HALT: instr_valid=0, halted=1, pc holds its last value. Leave HALT only via start or reset.
- Async reset mid-operation: immediate return to the reset values. Any pending branch is discarded.

## Timing
- Start latency: start sampled at edge N gives instr_valid=1 at pc=0 from cycle N+1.
- Issue: one instruction per cycle at full throughput with instr_ready held high.
- Branch: transfer at edge N gives instr_valid=0 from N+1. br_resolve at edge M (M >= N+1) gives the target instruction valid in cycle M+1. The minimum bubble is 1 cycle.
- HALT entry: halted=1 in the cycle after the last transfer or resolve. instr_valid drops in that same cycle.

## Test plan
- Load 5 words 00_01_10_11, 01_00_01_10, 10_00_01_00, 00_11_10_01, 00_00_00_00; set prog_len=5 and pulse start with ready=1 -> opcodes 00,01,10,00,00 at pc 0..4 on consecutive cycles; halted=1 after pc=4 transfers.
- Set ready low for 3 cycles at pc=2 -> instr, opcode and pc held constant and no PC advance; issue resumes at pc=3.
- Branch 11_00_00_01 at pc=1 with prog_len=6, br_resolve delayed 2 cycles with taken=1 -> instr_valid=0 for 2 cycles, then valid at pc=3. Repeat with taken=0 -> valid at pc=2.
- Branch imm=11 at pc=3, taken twice then not taken -> pc sequence 3,3,3,4. Then branch to target >= prog_len -> halted=1 with no further valid.
- prog_len=0 and start -> HALT next cycle with instr_valid never high. load_en during RUN -> memory unchanged, verified by a rerun.
- Assert reset_n low mid-RUN and mid-WAIT_BR -> outputs immediately at reset values. A new start runs from pc=0 with memory contents retained.
